// File: rtl/riscv_biu_ahb_burst.sv
// riscv_biu_ahb_burst: turns cache BIU strobe/burst requests into AHB3-Lite
// master transfers (SINGLE, INCR4/8/16, WRAP4/8/16) with the address phase of
// one beat overlapping the data phase of the previous one, back-to-back bursts
// and two-cycle error responses.
module riscv_biu_ahb_burst #(
  parameter int XLEN = 32,
  parameter int PLEN = XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            biu_stb_i,
  output logic            biu_stb_ack_o,
  output logic            biu_d_ack_o,
  input  logic [PLEN-1:0] biu_adri_i,
  output logic [PLEN-1:0] biu_adro_o,
  input  logic [2:0]      biu_size_i,
  input  logic [2:0]      biu_type_i,
  input  logic            biu_lock_i,
  input  logic [2:0]      biu_prot_i,
  input  logic            biu_we_i,
  input  logic [XLEN-1:0] biu_d_i,
  output logic [XLEN-1:0] biu_q_o,
  output logic            biu_ack_o,
  output logic            biu_err_o,
  output logic            HSEL,
  output logic [PLEN-1:0] HADDR,
  output logic [XLEN-1:0] HWDATA,
  input  logic [XLEN-1:0] HRDATA,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic            HMASTLOCK,
  input  logic            HREADY,
  input  logic            HRESP
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  localparam logic [2:0] BT_SINGLE = 3'b000;
  localparam logic [2:0] BT_INCR   = 3'b001;
  localparam logic [2:0] BT_WRAP4  = 3'b010;
  localparam logic [2:0] BT_INCR4  = 3'b011;
  localparam logic [2:0] BT_WRAP8  = 3'b100;
  localparam logic [2:0] BT_INCR8  = 3'b101;
  localparam logic [2:0] BT_WRAP16 = 3'b110;
  localparam logic [2:0] BT_INCR16 = 3'b111;

  localparam logic [PLEN-1:0] ONE = {{(PLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_ERR} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [1:0]      htrans_r;
  logic            dvalid;
  logic [PLEN-1:0] adro_r;

  logic err_any, err_first, acc, last_acc;

  // Remaining beats after the first one, for the burst length encoded in type.
  function automatic logic [3:0] type2cnt(input logic [2:0] t);
    case (t)
      BT_WRAP4,  BT_INCR4:  return 4'd3;
      BT_WRAP8,  BT_INCR8:  return 4'd7;
      BT_WRAP16, BT_INCR16: return 4'd15;
      default:              return 4'd0;
    endcase
  endfunction

  // Next beat address; incrementing bursts use an all-ones mask so the same
  // expression covers both the linear and the wrapping case.
  function automatic logic [PLEN-1:0] next_addr(input logic [PLEN-1:0] a,
                                                input logic [2:0]      sz,
                                                input logic [2:0]      bt);
    logic [PLEN-1:0] inc, mask;
    inc = ONE << sz;
    case (bt)
      BT_WRAP4:  mask = (inc << 2) - ONE;
      BT_WRAP8:  mask = (inc << 3) - ONE;
      BT_WRAP16: mask = (inc << 4) - ONE;
      default:   mask = '1;
    endcase
    return (a & ~mask) | ((a + inc) & mask);
  endfunction

  // An error response is in progress whenever the live data phase sees HRESP.
  assign err_any   = dvalid & HRESP;
  assign err_first = err_any & ~HREADY;
  assign acc       = HREADY & (htrans_r != HT_IDLE);
  assign last_acc  = (state == ST_ADDR) & acc & (cnt == 4'd0);

  assign biu_stb_ack_o = biu_stb_i & HREADY & ((state == ST_IDLE) | last_acc) & ~err_any;
  assign biu_d_ack_o   = acc & HWRITE;
  assign biu_ack_o     = dvalid & HREADY & ~HRESP;
  assign biu_err_o     = dvalid & HREADY & HRESP;
  assign biu_q_o       = dvalid ? HRDATA : '0;
  assign biu_adro_o    = adro_r;

  // The pending beat is withdrawn in the very first error cycle.
  assign HTRANS = err_first ? HT_IDLE : htrans_r;

  // Address-phase FSM: loads a new burst, steps beats, aborts on error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      htrans_r  <= HT_IDLE;
      HSEL      <= 1'b0;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'b000;
      HBURST    <= BT_SINGLE;
      HPROT     <= 4'b0000;
      HMASTLOCK <= 1'b0;
    end else if (err_first) begin
      state    <= ST_ERR;
      htrans_r <= HT_IDLE;
      HSEL     <= 1'b0;
      cnt      <= 4'd0;
    end else if (biu_stb_ack_o) begin
      state     <= ST_ADDR;
      htrans_r  <= HT_NONSEQ;
      HSEL      <= 1'b1;
      HADDR     <= biu_adri_i;
      HWRITE    <= biu_we_i;
      HSIZE     <= biu_size_i;
      HBURST    <= (biu_type_i == BT_INCR) ? BT_SINGLE : biu_type_i;
      HPROT     <= {biu_prot_i[2], 1'b0, biu_prot_i[1], biu_prot_i[0]};
      HMASTLOCK <= biu_lock_i;
      cnt       <= type2cnt(biu_type_i);
    end else begin
      case (state)
        ST_ADDR: if (acc) begin
          if (cnt != 4'd0) begin
            htrans_r <= HT_SEQ;
            HADDR    <= next_addr(HADDR, HSIZE, HBURST);
            cnt      <= cnt - 4'd1;
          end else begin
            state    <= ST_IDLE;
            htrans_r <= HT_IDLE;
            HSEL     <= 1'b0;
          end
        end
        ST_ERR: if (HREADY) state <= ST_IDLE;
        default: ;
      endcase
    end
  end

  // Data phase: tracks the beat in flight and latches write data on accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dvalid <= 1'b0;
      adro_r <= '0;
      HWDATA <= '0;
    end else if (HREADY) begin
      dvalid <= acc;
      if (acc) adro_r <= HADDR;
      if (acc & HWRITE) HWDATA <= biu_d_i;
    end
  end

endmodule

// File: doc/riscv_biu_ahb_burst.md
Name: riscv_biu_ahb_burst

Overview:
- Bus Interface Unit directly downstream of the cache BIU controller.
- Accepts the controller's biu_* strobe/burst requests and converts them into AHB3-Lite master transfers: SINGLE, INCR4/8/16, WRAP4/8/16.
- Returns per-beat read data, write-data requests, acknowledges and errors with the beat address.
- Handles the AHB pipeline (address phase overlaps previous data phase) and back-to-back bursts.

Parameters:
- XLEN, 32, data width (32 or 64).
- PLEN, XLEN, physical address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: one clock, reset asynchronous and active-high.
- biu_stb_i  in  1  request a new (burst) transfer.
- biu_stb_ack_o  out  1  request accepted; adri/size/type/we/d/prot/lock sampled this cycle.
- biu_d_ack_o  out  1  write beat address accepted; present next biu_d_i next cycle.
- biu_adri_i  in  PLEN  start address.
- biu_adro_o  out  PLEN  address of beat reported by biu_ack_o/biu_err_o.
- biu_size_i  in  3  biu_size_t, bytes = 2^size.
- biu_type_i  in  3  biu_type_t burst type.
- biu_lock_i  in  1  locked transfer.
- biu_prot_i  in  3  biu_prot_t.
- biu_we_i  in  1  write.
- biu_d_i  in  XLEN  write data.
- biu_q_o  out  XLEN  read data.
- biu_ack_o  out  1  beat completed OK.
- biu_err_o  out  1  beat completed with error; burst aborted.
- HSEL  out  1.
- HADDR  out  PLEN.
- HWDATA  out  XLEN.
- HRDATA  in  XLEN.
- HWRITE  out  1.
- HSIZE  out  3.
- HBURST  out  3.
- HPROT  out  4.
- HTRANS  out  2.
- HMASTLOCK  out  1.
- HREADY  in  1.
- HRESP  in  1.

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE.
  - HSEL=0, HTRANS=IDLE(00), HWRITE=0, HADDR=0, HWDATA=0, HSIZE=0, HBURST=0, HPROT=0, HMASTLOCK=0.
  - Data-phase valid cleared.
  - biu_ack_o=biu_err_o=biu_d_ack_o=biu_stb_ack_o=0; biu_q_o=0; biu_adro_o=0.
  - Reset mid-burst drops the burst silently; no ack/err is issued.
- Beat counter (4 bits):
  - Loaded with type2cnt: SINGLE/INCR=0, x4=3, x8=7, x16=15.
  - Decrements on every accepted address phase (HREADY=1 and HTRANS≠IDLE).
  - INCR (undefined length) is issued as a single beat with HBURST=SINGLE.
- State machine:
  - IDLE→ADDR when biu_stb_i & HREADY.
  - ADDR→ADDR on the next beat while count≠0.
  - ADDR→IDLE after the last beat is accepted, unless biu_stb_i is high (back-to-back: new NONSEQ issued in the same cycle, no IDLE gap).
  - On error, ADDR→ERR; ERR→IDLE when HREADY=1.
- Combinational: biu_stb_ack_o = biu_stb_i & HREADY & (IDLE or last beat accepted this cycle) & ~error.
- Address phase (registered on biu_stb_ack_o):
  - HADDR=biu_adri_i, HTRANS=NONSEQ, HSEL=1.
  - HSIZE/HBURST/HWRITE/HPROT/HMASTLOCK from inputs.
  - HPROT maps biu_prot: [0]=data, [1]=privileged, [2]=bufferable=0, [3]=cacheable.
  - Subsequent beats: HTRANS=SEQ, HADDR advanced when HREADY=1.
- Address arithmetic:
  - inc=2^HSIZE.
  - INCRn: HADDR+inc.
  - WRAPn: wrap mask = n·inc−1; next = (HADDR & ~mask) | ((HADDR+inc) & mask).
  - All in PLEN bits, modulo 2^PLEN.
- Control held stable while HREADY=0 (wait states); no new address issued.
- Write data:
  - HWDATA registered from biu_d_i when a write address phase is accepted (data phase one cycle later).
  - biu_d_ack_o = accepted write address phase; the controller shifts its buffer.
- Data phase:
  - Valid set on each accepted address phase; carries beat address into biu_adro_o.
  - biu_ack_o = valid & HREADY & ~HRESP; biu_q_o = HRDATA (writes: don't care).
- Error (AHB two-cycle):
  - First cycle (HRESP=1, HREADY=0): drive HTRANS=IDLE in the same cycle; cancel remaining beats; counter cleared.
  - Second cycle (HREADY=1): biu_err_o=1 for exactly one cycle.
  - Remaining beats are never acked, so the controller's inflight count still sees one err per issued beat only if the address was accepted.
- Simultaneous events:
  - Last data-phase ack and new NONSEQ in the same cycle are both legal.
  - biu_stb_i during ERR is not acked until IDLE.

Test Plan:
- SINGLE read 0x100, size word, HREADY=1 → HTRANS NONSEQ one cycle, biu_ack_o one cycle later with biu_q_o=HRDATA, biu_adro_o=0x100.
- WRAP4 read at 0x108, XLEN=32 → HADDR 0x108,0x10C,0x100,0x104; NONSEQ,SEQ,SEQ,SEQ; 4 acks with matching biu_adro_o.
- WRAP4 write at 0x0, 2 wait states on beat 2 → HADDR/HWDATA held; biu_d_ack_o exactly 4 pulses; HWDATA sequence equals supplied data.
- INCR8 read, HRESP error on beat 3 → HTRANS=IDLE in first error cycle; biu_err_o one pulse with biu_adro_o=start+8; acks only for beats 1–2.
- Back-to-back WRAP4 read then SINGLE write with biu_stb_i held → NONSEQ of second transfer in the cycle after the last SEQ, no IDLE gap.
- rst_i asserted during beat 2 of WRAP8 → HTRANS=IDLE, HSEL=0 immediately; no ack/err after reset release.
